// File: rtl/wb_writeback_unit.sv
// wb_writeback_unit: MEM/WB pipeline register with load extraction, writeback source select and optional retire counter
// Ports:
//   Clk, Rst            single rising-edge clock, asynchronous active-high reset
//   In_Valid/Stall/Flush slot valid, hold-stage, kill-incoming-slot controls
//   RegWrite/WriteReg   destination write enable and register index
//   MemToReg            source: 0=ALUResult 1=load data 2=PC 3=zero
//   LoadType/ByteOffset load width/sign and byte address of the load
//   ALUResult/ReadData/PC candidate writeback sources
//   WB_Valid, RegWrite_Out, WriteReg_Out, MemToReg_Out  registered writeback outputs
//   RetireCount         retired-instruction counter, only when WB_RETIRE_COUNT_EN is defined
module wb_writeback_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              In_Valid,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              RegWrite,
  input  logic [REG_AW-1:0] WriteReg,
  input  logic [1:0]        MemToReg,
  input  logic [2:0]        LoadType,
  input  logic [1:0]        ByteOffset,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] ReadData,
  input  logic [DATA_W-1:0] PC,
  output logic              WB_Valid,
  output logic              RegWrite_Out,
  output logic [REG_AW-1:0] WriteReg_Out,
  output logic [DATA_W-1:0] MemToReg_Out
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [31:0]       RetireCount
`endif
);
  logic [7:0]        byte_d;
  logic [15:0]       half_d;
  logic [DATA_W-1:0] load_d;
  logic [DATA_W-1:0] wb_d;
  logic              reg_write_q;
  assign byte_d = ReadData[{ByteOffset, 3'b000} +: 8];
  // Halfword loads ignore ByteOffset[0]: misaligned halves read the aligned half.
  assign half_d = ReadData[{ByteOffset[1], 4'b0000} +: 16];
  always_comb begin
    load_d = (LoadType == 3'd1) ? {{(DATA_W-8){byte_d[7]}}, byte_d} :
             (LoadType == 3'd2) ? {{(DATA_W-8){1'b0}}, byte_d} :
             (LoadType == 3'd3) ? {{(DATA_W-16){half_d[15]}}, half_d} :
             (LoadType == 3'd4) ? {{(DATA_W-16){1'b0}}, half_d} :
             ReadData;
    wb_d = (MemToReg == 2'd0) ? ALUResult :
           (MemToReg == 2'd1) ? load_d :
           (MemToReg == 2'd2) ? PC : '0;
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      WB_Valid     <= 1'b0;
      reg_write_q  <= 1'b0;
      WriteReg_Out <= '0;
      MemToReg_Out <= '0;
    end else begin
      if (Flush) WB_Valid <= 1'b0;
      else if (!Stall) WB_Valid <= In_Valid;
      if (!Stall) begin
        reg_write_q  <= RegWrite;
        WriteReg_Out <= WriteReg;
        MemToReg_Out <= wb_d;
      end
    end
  end
  // Register 0 is hardwired to zero, so writes to it never reach the file.
  assign RegWrite_Out = WB_Valid & reg_write_q & (|WriteReg_Out);
`ifdef WB_RETIRE_COUNT_EN
  // The occupant retires when the stage advances; a flush only kills the incoming slot.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) RetireCount <= '0;
    else if (WB_Valid && !Stall) RetireCount <= RetireCount + 32'd1;
  end
`endif
endmodule

// File: tb/tb_wb_writeback_unit.sv
// tb_wb_writeback_unit: scoreboard bench for wb_writeback_unit
module tb_wb_writeback_unit;
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        In_Valid = 1'b0, Stall = 1'b0, Flush = 1'b0, RegWrite = 1'b0;
  logic [4:0]  WriteReg = '0;
  logic [1:0]  MemToReg = '0;
  logic [2:0]  LoadType = '0;
  logic [1:0]  ByteOffset = '0;
  logic [31:0] ALUResult = '0, ReadData = '0, PC = '0;
  logic        WB_Valid, RegWrite_Out;
  logic [4:0]  WriteReg_Out;
  logic [31:0] MemToReg_Out;
`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] RetireCount;
`endif

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic        v;
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] d;
    logic        chk_data;
    string       name;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0]  m2r;
    logic [2:0]  lt;
    logic [1:0]  bo;
    logic        iv;
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [31:0] pc;
    logic [31:0] exp_d;
    logic        exp_rw;
    string       name;
  } vec_t;

  wb_writeback_unit #(.DATA_W(32), .REG_AW(5)) dut (
    .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .Stall(Stall), .Flush(Flush),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .MemToReg(MemToReg),
    .LoadType(LoadType), .ByteOffset(ByteOffset), .ALUResult(ALUResult),
    .ReadData(ReadData), .PC(PC), .WB_Valid(WB_Valid), .RegWrite_Out(RegWrite_Out),
    .WriteReg_Out(WriteReg_Out), .MemToReg_Out(MemToReg_Out)
`ifdef WB_RETIRE_COUNT_EN
    , .RetireCount(RetireCount)
`endif
  );

  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, compared=%0d", compared);
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic iv, input logic st, input logic fl, input logic rw,
                       input logic [4:0] wr, input logic [1:0] m2r, input logic [2:0] lt,
                       input logic [1:0] bo, input logic [31:0] alu, input logic [31:0] rd,
                       input logic [31:0] pc);
    In_Valid = iv; Stall = st; Flush = fl; RegWrite = rw; WriteReg = wr; MemToReg = m2r;
    LoadType = lt; ByteOffset = bo; ALUResult = alu; ReadData = rd; PC = pc;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    @(posedge Clk); #1;
    compared += 4;
    if (WB_Valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", WB_Valid); end
    if (RegWrite_Out !== 1'b0) begin mismatched++; $display("FAIL reset_rw: got %b want 0", RegWrite_Out); end
    if (WriteReg_Out !== 5'd0) begin mismatched++; $display("FAIL reset_wr: got %0d want 0", WriteReg_Out); end
    if (MemToReg_Out !== 32'd0) begin mismatched++; $display("FAIL reset_data: got %h want 0", MemToReg_Out); end
    Rst = 1'b0;
  endtask

  task automatic test_sources();
    exp_t e;
    vec_t vt[11];
    vt[0]  = '{2'd1, 3'd0, 2'd0, 1'b1, 1'b1, 5'd7,  32'h0,        32'h8000_00F0, 32'h0,        32'h8000_00F0, 1'b1, "word_load"};
    vt[1]  = '{2'd1, 3'd1, 2'd1, 1'b1, 1'b1, 5'd8,  32'h0,        32'h1234_80FF, 32'h0,        32'hFFFF_FF80, 1'b1, "lb_off1"};
    vt[2]  = '{2'd1, 3'd2, 2'd1, 1'b1, 1'b1, 5'd9,  32'h0,        32'h1234_80FF, 32'h0,        32'h0000_0080, 1'b1, "lbu_off1"};
    vt[3]  = '{2'd1, 3'd3, 2'd2, 1'b1, 1'b1, 5'd10, 32'h0,        32'h1234_80FF, 32'h0,        32'h0000_1234, 1'b1, "lh_off2"};
    vt[4]  = '{2'd1, 3'd4, 2'd0, 1'b1, 1'b1, 5'd11, 32'h0,        32'h1234_80FF, 32'h0,        32'h0000_80FF, 1'b1, "lhu_off0"};
    vt[5]  = '{2'd1, 3'd3, 2'd1, 1'b1, 1'b1, 5'd12, 32'h0,        32'h1234_80FF, 32'h0,        32'hFFFF_80FF, 1'b1, "lh_off1_aligned"};
    vt[6]  = '{2'd1, 3'd1, 2'd3, 1'b1, 1'b1, 5'd13, 32'h0,        32'h1234_80FF, 32'h0,        32'h0000_0012, 1'b1, "lb_off3"};
    vt[7]  = '{2'd1, 3'd7, 2'd3, 1'b1, 1'b1, 5'd14, 32'h0,        32'h1234_80FF, 32'h0,        32'h1234_80FF, 1'b1, "lt7_word"};
    vt[8]  = '{2'd2, 3'd0, 2'd0, 1'b1, 1'b1, 5'd15, 32'hDEAD,     32'h0,         32'h0040_0008, 32'h0040_0008, 1'b1, "sel_pc"};
    vt[9]  = '{2'd3, 3'd0, 2'd0, 1'b1, 1'b1, 5'd16, 32'hDEAD,     32'hBEEF,      32'h1111,      32'h0000_0000, 1'b1, "sel_zero"};
    vt[10] = '{2'd0, 3'd0, 2'd0, 1'b1, 1'b1, 5'd0,  32'hCAFE_0001, 32'h0,        32'h0,        32'hCAFE_0001, 1'b0, "wr_x0"};
    foreach (vt[i]) begin
      drive(vt[i].iv, 1'b0, 1'b0, vt[i].rw, vt[i].wr, vt[i].m2r, vt[i].lt, vt[i].bo, vt[i].alu, vt[i].rd, vt[i].pc);
      sb.push_back('{1'b1, vt[i].exp_rw, vt[i].wr, vt[i].exp_d, 1'b1, vt[i].name});
      @(posedge Clk); #1;
      e = sb.pop_front();
      compared += 4;
      if (WB_Valid !== e.v) begin mismatched++; $display("FAIL %s valid: got %b want %b", e.name, WB_Valid, e.v); end
      if (RegWrite_Out !== e.rw) begin mismatched++; $display("FAIL %s rw: got %b want %b", e.name, RegWrite_Out, e.rw); end
      if (WriteReg_Out !== e.wr) begin mismatched++; $display("FAIL %s wr: got %0d want %0d", e.name, WriteReg_Out, e.wr); end
      if (MemToReg_Out !== e.d) begin mismatched++; $display("FAIL %s data: got %h want %h", e.name, MemToReg_Out, e.d); end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 2'd0, 3'd0, 2'd0, 32'h9, 32'h0, 32'h0);
    sb.push_back('{1'b0, 1'b0, 5'd3, 32'h9, 1'b0, "invalid_slot"});
    @(posedge Clk); #1;
    e = sb.pop_front();
    compared += 2;
    if (WB_Valid !== e.v) begin mismatched++; $display("FAIL %s valid: got %b want %b", e.name, WB_Valid, e.v); end
    if (RegWrite_Out !== e.rw) begin mismatched++; $display("FAIL %s rw: got %b want %b", e.name, RegWrite_Out, e.rw); end
  endtask

  task automatic test_stall_flush();
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 2'd0, 3'd0, 2'd0, 32'h55, 32'h0, 32'h0);
                 sb.push_back('{1'b1, 1'b1, 5'd3, 32'h55, 1'b1, "capture_55"}); end
        1, 2, 3: begin drive(i[0], 1'b1, 1'b0, 1'b0, 5'(9 + i), 2'd0, 3'd0, 2'd0, 32'hAA + i, 32'h0, 32'h0);
                 sb.push_back('{1'b1, 1'b1, 5'd3, 32'h55, 1'b1, "stall_hold"}); end
        4: begin drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 2'd0, 3'd0, 2'd0, 32'h66, 32'h0, 32'h0);
                 sb.push_back('{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, "stall_flush"}); end
        5: begin drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 2'd0, 3'd0, 2'd0, 32'h66, 32'h0, 32'h0);
                 sb.push_back('{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, "flush_valid_in"}); end
        default: begin drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd21, 2'd0, 3'd0, 2'd0, 32'h77, 32'h0, 32'h0);
                 sb.push_back('{1'b1, 1'b1, 5'd21, 32'h77, 1'b1, "after_flush"}); end
      endcase
      @(posedge Clk); #1;
      e = sb.pop_front();
      compared += 2;
      if (WB_Valid !== e.v) begin mismatched++; $display("FAIL %s valid: got %b want %b", e.name, WB_Valid, e.v); end
      if (RegWrite_Out !== e.rw) begin mismatched++; $display("FAIL %s rw: got %b want %b", e.name, RegWrite_Out, e.rw); end
      if (e.chk_data) begin
        compared += 2;
        if (WriteReg_Out !== e.wr) begin mismatched++; $display("FAIL %s wr: got %0d want %0d", e.name, WriteReg_Out, e.wr); end
        if (MemToReg_Out !== e.d) begin mismatched++; $display("FAIL %s data: got %h want %h", e.name, MemToReg_Out, e.d); end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      a = $urandom;
      drive(1'b1, 1'b0, 1'b0, 1'b1, 5'(i + 1), 2'd0, 3'd0, 2'd0, a, ~a, 32'h0);
      sb.push_back('{1'b1, 1'b1, 5'(i + 1), a, 1'b1, "b2b"});
      @(posedge Clk); #1;
      e = sb.pop_front();
      compared += 3;
      if (RegWrite_Out !== e.rw) begin mismatched++; $display("FAIL %s rw: got %b want %b", e.name, RegWrite_Out, e.rw); end
      if (WriteReg_Out !== e.wr) begin mismatched++; $display("FAIL %s wr: got %0d want %0d", e.name, WriteReg_Out, e.wr); end
      if (MemToReg_Out !== e.d) begin mismatched++; $display("FAIL %s data: got %h want %h", e.name, MemToReg_Out, e.d); end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 2'd0, 3'd0, 2'd0, 32'h1234, 32'h0, 32'h0);
    @(posedge Clk); #3;
    Rst = 1'b1;
    #1;
    compared += 4;
    if (WB_Valid !== 1'b0) begin mismatched++; $display("FAIL async_rst valid: got %b want 0", WB_Valid); end
    if (RegWrite_Out !== 1'b0) begin mismatched++; $display("FAIL async_rst rw: got %b want 0", RegWrite_Out); end
    if (WriteReg_Out !== 5'd0) begin mismatched++; $display("FAIL async_rst wr: got %0d want 0", WriteReg_Out); end
    if (MemToReg_Out !== 32'd0) begin mismatched++; $display("FAIL async_rst data: got %h want 0", MemToReg_Out); end
    @(posedge Clk); #1;
    Rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 2'd0, 3'd0, 2'd0, 32'h4321, 32'h0, 32'h0);
    @(posedge Clk); #1;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 2'd0, 3'd0, 2'd0, 32'h9999, 32'h0, 32'h0);
    @(posedge Clk); #3;
    Rst = 1'b1;
    #1;
    compared += 2;
    if (WB_Valid !== 1'b0) begin mismatched++; $display("FAIL stall_rst valid: got %b want 0", WB_Valid); end
    if (MemToReg_Out !== 32'd0) begin mismatched++; $display("FAIL stall_rst data: got %h want 0", MemToReg_Out); end
    @(posedge Clk); #3;
    Rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd6, 2'd0, 3'd0, 2'd0, 32'h77, 32'h0, 32'h0);
    sb.push_back('{1'b1, 1'b1, 5'd6, 32'h77, 1'b1, "post_rst_capture"});
    @(posedge Clk); #1;
    e = sb.pop_front();
    compared += 4;
    if (WB_Valid !== e.v) begin mismatched++; $display("FAIL %s valid: got %b want %b", e.name, WB_Valid, e.v); end
    if (RegWrite_Out !== e.rw) begin mismatched++; $display("FAIL %s rw: got %b want %b", e.name, RegWrite_Out, e.rw); end
    if (WriteReg_Out !== e.wr) begin mismatched++; $display("FAIL %s wr: got %0d want %0d", e.name, WriteReg_Out, e.wr); end
    if (MemToReg_Out !== e.d) begin mismatched++; $display("FAIL %s data: got %h want %h", e.name, MemToReg_Out, e.d); end
  endtask

`ifdef WB_RETIRE_COUNT_EN
  task automatic test_retire_count();
    logic [31:0] want[6];
    logic        st[6];
    logic        fl[6];
    want = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 32'h0000_0002};
    st   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    fl   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 2'd0, 3'd0, 2'd0, 32'h1, 32'h0, 32'h0);
    @(posedge Clk); #1;
    force dut.RetireCount = 32'hFFFF_FFFE;
    #1;
    release dut.RetireCount;
    #1;
    compared++;
    if (RetireCount !== 32'hFFFF_FFFE) begin mismatched++; $display("FAIL retire_preload: got %h want fffffffe", RetireCount); end
    for (int i = 0; i < 6; i++) begin
      Stall = st[i]; Flush = fl[i];
      @(posedge Clk); #1;
      compared++;
      if (RetireCount !== want[i]) begin mismatched++; $display("FAIL retire_%0d: got %h want %h", i, RetireCount, want[i]); end
    end
    Stall = 1'b0; Flush = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_sources();
    test_stall_flush();
    test_back_to_back();
    test_async_reset();
`ifdef WB_RETIRE_COUNT_EN
    test_retire_count();
`endif
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/wb_writeback_unit.md
WB_WRITEBACK_UNIT -- requirements
Module: wb_writeback_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning datapath width (≥16 and a multiple of 8).
REQ-002 SHALL have parameter REG_AW, default 5, meaning register-file address width.
REQ-003 Clk  in  1  single clock for the block; all state updates on the rising edge.
REQ-004 Rst  in  1  asynchronous, active-high reset.
REQ-005 In_Valid  in  1  MEM/WB slot holds a real instruction.
REQ-006 Stall  in  1  hold the pipeline register.
REQ-007 Flush  in  1  kill the instruction being captured.
REQ-008 RegWrite  in  1  instruction writes the register file.
REQ-009 WriteReg  in  REG_AW  destination register.
REQ-010 MemToReg  in  2  source select: 0=ALUResult, 1=load data, 2=PC, 3=zero.
REQ-011 LoadType  in  3  0=word, 1=byte signed, 2=byte unsigned, 3=half signed, 4=half unsigned; 5..7 treated as word.
REQ-012 ByteOffset  in  2  address bits [1:0] of the load.
REQ-013 ALUResult, ReadData, PC  in  DATA_W each  candidate writeback sources.
REQ-014 WB_Valid  out  1  registered slot valid.
REQ-015 RegWrite_Out  out  1  register-file write enable.
REQ-016 WriteReg_Out  out  REG_AW  register-file write address.
REQ-017 MemToReg_Out  out  DATA_W  register-file write data (also the forwarding source).
REQ-018 RetireCount  out  32  retired-instruction counter (present only under REQ-031).

Function
REQ-019 The block SHALL register all inputs in one MEM/WB stage; outputs SHALL reflect inputs one clock after capture (latency 1).
REQ-020 Load extraction SHALL be combinational before the register: byte = ReadData[8*ByteOffset +: 8]; half = ReadData[16*ByteOffset[1] +: 16], with ByteOffset[0] ignored; signed types sign-extend and unsigned types zero-extend to DATA_W.
REQ-021 MemToReg_Out SHALL be the registered selection per REQ-010, where select 1 uses the extracted load data.
REQ-022 Stall=1 with Flush=0: all registers SHALL hold their values; outputs SHALL be unchanged.
REQ-023 Flush=1: WB_Valid SHALL go 0 on the next edge regardless of Stall or In_Valid; flush wins over stall.
REQ-024 Otherwise WB_Valid SHALL take In_Valid on each edge.
REQ-025 RegWrite_Out SHALL equal WB_Valid AND the registered RegWrite AND (WriteReg_Out != 0); writes to register 0 SHALL be suppressed.
REQ-026 Data and address registers MAY update when In_Valid=0; consumers SHALL qualify them only via WB_Valid and RegWrite_Out.

Reset
REQ-027 Asserting Rst SHALL immediately clear WB_Valid, RegWrite_Out, WriteReg_Out, MemToReg_Out and RetireCount to 0, without waiting for a clock edge.
REQ-028 Rst asserted mid-stall SHALL still clear all state; after release, the first edge with In_Valid=1 SHALL capture normally.
REQ-029 Rst SHALL dominate Stall and Flush.

Configuration
REQ-030 Macro WB_RETIRE_COUNT_EN selects the retire counter.
REQ-031 With the macro defined: RetireCount SHALL increment by 1 on each edge where WB_Valid=1 and Stall=0. It SHALL count on the edge that retires the instruction occupying the stage, SHALL be unaffected by Flush of the incoming slot, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-032 Without the macro: the RetireCount port and its counter logic SHALL be absent.

Verification
REQ-033 Word load: MemToReg=1, LoadType=0, ReadData=0x8000_00F0, RegWrite=1, WriteReg=7 -> next cycle MemToReg_Out=0x8000_00F0, RegWrite_Out=1, WriteReg_Out=7.
REQ-034 Byte and half loads: ReadData=0x1234_80FF. LoadType=1, ByteOffset=1 -> 0xFFFF_FF80. LoadType=2, ByteOffset=1 -> 0x0000_0080. LoadType=3, ByteOffset=2 -> 0x0000_1234. LoadType=4, ByteOffset=0 -> 0x0000_80FF.
REQ-035 Source selects: MemToReg=2, PC=0x0040_0008 -> 0x0040_0008. MemToReg=3 -> 0. Any valid write with WriteReg=0 -> RegWrite_Out=0.
REQ-036 Stall and flush: capture ALUResult=0x55, then Stall=1 for 3 cycles while inputs change -> output holds 0x55. Stall=1 with Flush=1 -> WB_Valid=0 next cycle.
REQ-037 Asynchronous reset: assert Rst between clock edges while WB_Valid=1 -> all outputs 0 before the next edge.
REQ-038 With WB_RETIRE_COUNT_EN: preload the counter to 0xFFFF_FFFE via 2^32-2 retires (or a force), then 3 valid unstalled retires -> RetireCount = 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000, 0x0000_0001. A stalled cycle -> no increment.
